ppu_bg_fetch_sequencer: RTL and testbench
=========================================

// Module: ppu_bg_fetch_sequencer
// PURPOSE
//  Initiator side of the PPU memory port served by memory_manager_top.
//  - Per scanline, issues the NES background fetch sequence for each tile:
//    nametable byte, attribute byte, pattern low plane, pattern high plane.
//  - Presents one assembled tile (two pattern planes plus a 2-bit palette) per 8 clocks
//    to the PPU background shifters.
//  - Advances coarse X with horizontal nametable wrap.
// PARAMETERS
//  TILES_PER_LINE  34  tiles fetched per line_start (32 visible + 2 prefetch); legal range 1..63
//  RD_LATENCY      1   clocks from mem_rd_req to valid mem_rd_data; only 1 is supported
// PORTS
//  clk            in   1   system clock, single domain
//  rst_n          in   1   asynchronous active-low reset
//  line_start     in   1   one-cycle pulse: load v_addr_in and begin a line burst
//  v_addr_in      in   15  loopy v: [4:0] coarse X, [9:5] coarse Y, [11:10] NT select, [14:12] fine Y
//  pt_base_sel    in   1   background pattern table: 0 -> 0x0000, 1 -> 0x1000
//  mem_addr       out  14  PPU address to the memory manager
//  mem_rd_req     out  1   read request, high for exactly one cycle per fetch
//  mem_rd_data    in   8   read data, valid the cycle after mem_rd_req
//  tile_lo        out  8   pattern low plane of the completed tile
//  tile_hi        out  8   pattern high plane of the completed tile
//  tile_attr      out  2   palette select of the completed tile
//  tile_valid     out  1   one-cycle pulse: tile_lo, tile_hi and tile_attr are updated
//  busy           out  1   high while a line burst is in progress
//  line_done      out  1   one-cycle pulse with the last tile_valid of the burst
// BEHAVIOUR
//  Reset (asynchronous, any state, including mid-burst)
//  - FSM returns to IDLE.
//  - Tile counter and internal v copy are cleared.
//  - All outputs are 0: mem_addr, mem_rd_req, tile_lo, tile_hi, tile_attr, tile_valid, busy, line_done.
//  FSM states
//  - IDLE, then NT, AT, PT_LO, PT_HI; each fetch state has sub-phase REQ then CAP.
//  - REQ: mem_rd_req=1 with the fetch address on mem_addr.
//  - CAP: mem_rd_req=0; mem_rd_data is latched at the end of the cycle.
//  - IDLE -> NT.REQ: line_start sampled high; v_addr_in is latched; busy goes 1.
//  - line_start while busy=1 is ignored.
//  - PT_HI.CAP -> NT.REQ if tiles_done < TILES_PER_LINE, else -> IDLE.
//  Fetch addresses (v = internal copy)
//  - NT:    0x2000 | v[11:0]
//  - AT:    0x23C0 | v[11:10]<<10 | v[9:7]<<3 | v[4:2]
//  - PT_LO: {pt_base_sel, nt_byte, 1'b0, v[14:12]}
//  - PT_HI: {pt_base_sel, nt_byte, 1'b1, v[14:12]}
//  Timing (cycle 0 = first NT.REQ cycle)
//  - Tile k requests occur at cycles 8k, 8k+2, 8k+4, 8k+6.
//  - tile_valid is high in cycle 8k+8. Outputs are registered and hold until the next tile_valid.
//  - tile_attr = at_byte[2s+1:2s], where s = {v[6], v[1]} (coarse Y bit 1, coarse X bit 1).
//    The value is captured before coarse X is incremented.
//  End of tile (coincident with the tile_valid edge)
//  - coarse X += 1.
//  - On coarse X = 31: coarse X wraps to 0 and v[10] toggles.
//  - Coarse Y, v[11] and fine Y never change inside the block.
//  End of burst
//  - line_done=1 in cycle 8*TILES_PER_LINE, together with the final tile_valid.
//  - busy=0 from that same cycle.
//  - A line_start in that cycle is accepted; the next NT.REQ follows in the next cycle.
//  pt_base_sel is sampled at each PT_LO.REQ / PT_HI.REQ, not latched at line_start.
// STRUCTURE
//  Shared include nes_ppu_defs.vh
//  - FSM state encodings.
//  - Constants: NT_BASE 0x2000, AT_OFFSET 0x3C0, PT_PLANE_HI bit 3.
//  - Field offsets of loopy v.
//  Sub-module ppu_coarse_x_incr (combinational)
//  - v in -> v out, with coarse X wrap and NT toggle.
//  - Reused later by the loopy-register block.
// TESTING
//  1. v_addr_in=0x0000, pt_base_sel=0, NT byte 0x24 at 0x2000
//     -> mem_addr 0x2000, 0x23C0, 0x0240, 0x0248 at cycles 0, 2, 4, 6.
//  2. Memory model returns AT=0xE4 with coarse X=2, coarse Y=2 (s=3)
//     -> tile_attr=2'b11; tile_valid pulses at cycle 8.
//  3. v_addr_in coarse X=30, TILES_PER_LINE=4
//     -> NT addresses 0x201E, 0x201F, 0x2400, 0x2401.
//  4. Default parameters
//     -> exactly 34 tile_valid pulses; line_done only on the 34th; busy low at cycle 272.
//  5. rst_n pulled low at cycle 13 of a burst
//     -> all outputs 0 immediately; mem_rd_req stays 0 until the next line_start.
//  6. line_start repeated at cycle 5
//     -> ignored; fetch addresses unchanged; a line_start at cycle 8*N restarts with no gap.

Source files
------------

// File: rtl/ppu_bg_fetch_sequencer_pkg.sv
// Shared definitions for the PPU background fetch path: FSM encoding, PPU address
// constants, loopy-v field offsets and small address-forming helpers.
package ppu_bg_fetch_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_NT_REQ = 4'd1,
      ST_NT_CAP = 4'd2,
      ST_AT_REQ = 4'd3,
      ST_AT_CAP = 4'd4,
      ST_LO_REQ = 4'd5,
      ST_LO_CAP = 4'd6,
      ST_HI_REQ = 4'd7,
      ST_HI_CAP = 4'd8
   } fetch_state_e;

   localparam logic [13:0] NT_BASE     = 14'h2000;
   localparam logic [13:0] AT_OFFSET   = 14'h03C0;
   localparam int          PT_PLANE_HI = 3;

   // loopy v layout: fine Y | NT select | coarse Y | coarse X
   localparam int V_CX_LSB = 0;
   localparam int V_CY_LSB = 5;
   localparam int V_NT_LSB = 10;
   localparam int V_FY_LSB = 12;

   function automatic logic [13:0] nt_fetch_addr(input logic [11:0] v_lo);
      return NT_BASE | {2'b00, v_lo};
   endfunction

   function automatic logic [13:0] at_fetch_addr(input logic [1:0] nt_sel,
                                                 input logic [2:0] cy_hi,
                                                 input logic [2:0] cx_hi);
      return NT_BASE | AT_OFFSET | {2'b00, nt_sel, 4'b0000, cy_hi, cx_hi};
   endfunction

   function automatic logic [13:0] pt_fetch_addr(input logic       base_sel,
                                                 input logic [7:0] tile_idx,
                                                 input logic       plane,
                                                 input logic [2:0] fine_y);
      logic [13:0] addr;
      addr = {1'b0, base_sel, tile_idx, 1'b0, fine_y};
      addr[PT_PLANE_HI] = plane;
      return addr;
   endfunction

   // s = {coarse Y bit 1, coarse X bit 1} picks one 2-bit quadrant of the attribute byte
   function automatic logic [1:0] attr_select(input logic [7:0] at_byte,
                                              input logic [1:0] s);
      return at_byte[{s, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/ppu_coarse_x_incr.sv
// Combinational coarse-X increment of loopy v: wraps coarse X at 31 and toggles the
// horizontal nametable select bit.
module ppu_coarse_x_incr
   import ppu_bg_fetch_sequencer_pkg::*;
(
   input  logic [14:0] v_in,
   output logic [14:0] v_out
);

   always_comb begin
      v_out = v_in;
      if (v_in[V_CX_LSB +: 5] == 5'd31) begin
         v_out[V_CX_LSB +: 5] = 5'd0;
         v_out[V_NT_LSB]      = ~v_in[V_NT_LSB];
      end else begin
         v_out[V_CX_LSB +: 5] = v_in[V_CX_LSB +: 5] + 5'd1;
      end
   end

endmodule

// File: rtl/ppu_bg_fetch_sequencer.sv
// Background tile fetch sequencer: per line burst, fetches NT/AT/PT-lo/PT-hi for each
// tile over 8 clocks and presents one assembled tile per 8 clocks.
module ppu_bg_fetch_sequencer
   import ppu_bg_fetch_sequencer_pkg::*;
#(
   parameter int TILES_PER_LINE = 34,
   parameter int RD_LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        line_start,
   input  logic [14:0] v_addr_in,
   input  logic        pt_base_sel,
   output logic [13:0] mem_addr,
   output logic        mem_rd_req,
   input  logic [7:0]  mem_rd_data,
   output logic [7:0]  tile_lo,
   output logic [7:0]  tile_hi,
   output logic [1:0]  tile_attr,
   output logic        tile_valid,
   output logic        busy,
   output logic        line_done
);

   if (RD_LATENCY != 1) begin : g_bad_latency
      $error("ppu_bg_fetch_sequencer: only RD_LATENCY = 1 is supported");
   end
   if (TILES_PER_LINE < 1 || TILES_PER_LINE > 63) begin : g_bad_tiles
      $error("ppu_bg_fetch_sequencer: TILES_PER_LINE must be 1..63");
   end

   localparam logic [5:0] LAST_IDX = 6'(TILES_PER_LINE - 1);

   fetch_state_e state_q, state_d;
   logic [14:0]  v_q, v_d, v_incr;
   logic [5:0]   tiles_done_q, tiles_done_d;
   logic [7:0]   nt_byte_q, nt_byte_d;
   logic [7:0]   at_byte_q, at_byte_d;
   logic [7:0]   lo_byte_q, lo_byte_d;
   logic [13:0]  mem_addr_q, mem_addr_d;
   logic         mem_rd_req_q, mem_rd_req_d;
   logic [7:0]   tile_lo_q, tile_lo_d;
   logic [7:0]   tile_hi_q, tile_hi_d;
   logic [1:0]   tile_attr_q, tile_attr_d;
   logic         tile_valid_q, tile_valid_d;
   logic         busy_q, busy_d;
   logic         line_done_q, line_done_d;

   ppu_coarse_x_incr u_cx_incr (
      .v_in  (v_q),
      .v_out (v_incr)
   );

   // Next-state and next-output logic; every REQ address is formed one cycle early so
   // mem_addr/mem_rd_req come straight from flops.
   always_comb begin
      state_d      = state_q;
      v_d          = v_q;
      tiles_done_d = tiles_done_q;
      nt_byte_d    = nt_byte_q;
      at_byte_d    = at_byte_q;
      lo_byte_d    = lo_byte_q;
      mem_addr_d   = mem_addr_q;
      mem_rd_req_d = 1'b0;
      tile_lo_d    = tile_lo_q;
      tile_hi_d    = tile_hi_q;
      tile_attr_d  = tile_attr_q;
      tile_valid_d = 1'b0;
      busy_d       = busy_q;
      line_done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (line_start) begin
               state_d      = ST_NT_REQ;
               v_d          = v_addr_in;
               tiles_done_d = 6'd0;
               busy_d       = 1'b1;
               mem_rd_req_d = 1'b1;
               mem_addr_d   = nt_fetch_addr(v_addr_in[11:0]);
            end
         end
         ST_NT_REQ: state_d = ST_NT_CAP;
         ST_NT_CAP: begin
            nt_byte_d    = mem_rd_data;
            state_d      = ST_AT_REQ;
            mem_rd_req_d = 1'b1;
            mem_addr_d   = at_fetch_addr(v_q[V_NT_LSB +: 2], v_q[V_CY_LSB + 2 +: 3],
                                         v_q[V_CX_LSB + 2 +: 3]);
         end
         ST_AT_REQ: state_d = ST_AT_CAP;
         ST_AT_CAP: begin
            at_byte_d    = mem_rd_data;
            state_d      = ST_LO_REQ;
            mem_rd_req_d = 1'b1;
            mem_addr_d   = pt_fetch_addr(pt_base_sel, nt_byte_q, 1'b0, v_q[V_FY_LSB +: 3]);
         end
         ST_LO_REQ: state_d = ST_LO_CAP;
         ST_LO_CAP: begin
            lo_byte_d    = mem_rd_data;
            state_d      = ST_HI_REQ;
            mem_rd_req_d = 1'b1;
            mem_addr_d   = pt_fetch_addr(pt_base_sel, nt_byte_q, 1'b1, v_q[V_FY_LSB +: 3]);
         end
         ST_HI_REQ: state_d = ST_HI_CAP;
         ST_HI_CAP: begin
            // Attribute quadrant uses v before the coarse-X step
            tile_lo_d    = lo_byte_q;
            tile_hi_d    = mem_rd_data;
            tile_attr_d  = attr_select(at_byte_q, {v_q[V_CY_LSB + 1], v_q[V_CX_LSB + 1]});
            tile_valid_d = 1'b1;
            v_d          = v_incr;
            tiles_done_d = tiles_done_q + 6'd1;
            if (tiles_done_q == LAST_IDX) begin
               state_d     = ST_IDLE;
               busy_d      = 1'b0;
               line_done_d = 1'b1;
            end else begin
               state_d      = ST_NT_REQ;
               mem_rd_req_d = 1'b1;
               mem_addr_d   = nt_fetch_addr(v_incr[11:0]);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         v_q          <= '0;
         tiles_done_q <= '0;
         nt_byte_q    <= '0;
         at_byte_q    <= '0;
         lo_byte_q    <= '0;
         mem_addr_q   <= '0;
         mem_rd_req_q <= 1'b0;
         tile_lo_q    <= '0;
         tile_hi_q    <= '0;
         tile_attr_q  <= '0;
         tile_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         line_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         v_q          <= v_d;
         tiles_done_q <= tiles_done_d;
         nt_byte_q    <= nt_byte_d;
         at_byte_q    <= at_byte_d;
         lo_byte_q    <= lo_byte_d;
         mem_addr_q   <= mem_addr_d;
         mem_rd_req_q <= mem_rd_req_d;
         tile_lo_q    <= tile_lo_d;
         tile_hi_q    <= tile_hi_d;
         tile_attr_q  <= tile_attr_d;
         tile_valid_q <= tile_valid_d;
         busy_q       <= busy_d;
         line_done_q  <= line_done_d;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_rd_req = mem_rd_req_q;
   assign tile_lo    = tile_lo_q;
   assign tile_hi    = tile_hi_q;
   assign tile_attr  = tile_attr_q;
   assign tile_valid = tile_valid_q;
   assign busy       = busy_q;
   assign line_done  = line_done_q;

endmodule

// File: tb/tb_ppu_bg_fetch_sequencer.sv
// Randomized bench for ppu_bg_fetch_sequencer: a PPU memory image feeds the read port and
// a tile-level model predicts every request, tile and burst flag cycle by cycle.
module tb_ppu_bg_fetch_sequencer;

   localparam int N = 34;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        line_start;
   logic [14:0] v_addr_in;
   logic        pt_base_sel;
   logic [13:0] mem_addr;
   logic        mem_rd_req;
   logic [7:0]  mem_rd_data;
   logic [7:0]  tile_lo;
   logic [7:0]  tile_hi;
   logic [1:0]  tile_attr;
   logic        tile_valid;
   logic        busy;
   logic        line_done;

   always #5 clk = ~clk;

   ppu_bg_fetch_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .line_start  (line_start),
      .v_addr_in   (v_addr_in),
      .pt_base_sel (pt_base_sel),
      .mem_addr    (mem_addr),
      .mem_rd_req  (mem_rd_req),
      .mem_rd_data (mem_rd_data),
      .tile_lo     (tile_lo),
      .tile_hi     (tile_hi),
      .tile_attr   (tile_attr),
      .tile_valid  (tile_valid),
      .busy        (busy),
      .line_done   (line_done)
   );

   logic [7:0]  mem [0:16383];
   logic        req_prev = 1'b0;
   logic [13:0] addr_prev = '0;

   // Read data is valid only in the cycle after the request; junk otherwise
   always @(negedge clk) begin
      if (req_prev) mem_rd_data = mem[addr_prev];
      else          mem_rd_data = 8'($urandom);
      req_prev  = mem_rd_req;
      addr_prev = mem_addr;
   end

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] exp_lo = '0;
   logic [7:0] exp_hi = '0;
   logic [1:0] exp_attr = '0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      else n_pass++;
   endtask

   // Tile k of a burst starting at v0, derived arithmetically from the fetch rules
   task automatic model_tile(input logic [14:0] v0, input int k, input logic pt,
                             output logic [13:0] a_nt, output logic [13:0] a_at,
                             output logic [13:0] a_lo, output logic [13:0] a_hi,
                             output logic [7:0] lo, output logic [7:0] hi,
                             output logic [1:0] attr);
      int t, cx, cy, fy, ntsel, sh;
      logic [7:0] ntb, atb;
      t     = int'(v0[4:0]) + k;
      cx    = t % 32;
      cy    = int'(v0[9:5]);
      fy    = int'(v0[14:12]);
      ntsel = int'(v0[11]) * 2 + (int'(v0[10]) ^ ((t / 32) % 2));
      a_nt  = 14'(8192 + ntsel * 1024 + cy * 32 + cx);
      a_at  = 14'(8192 + 960 + ntsel * 1024 + (cy / 4) * 8 + cx / 4);
      ntb   = mem[a_nt];
      atb   = mem[a_at];
      a_lo  = 14'(int'(pt) * 4096 + int'(ntb) * 16 + fy);
      a_hi  = 14'(int'(a_lo) + 8);
      lo    = mem[a_lo];
      hi    = mem[a_hi];
      sh    = ((cy / 2) % 2) * 4 + ((cx / 2) % 2) * 2;
      attr  = 2'((int'(atb) >> sh) & 3);
   endtask

   task automatic launch(input logic [14:0] v, input logic pt);
      line_start  = 1'b1;
      v_addr_in   = v;
      pt_base_sel = pt;
      @(negedge clk);
      line_start  = 1'b0;
      v_addr_in   = 15'($urandom);
   endtask

   // Called at the negedge of burst cycle 0; checks cycles 0..8N.
   task automatic check_burst(input logic [14:0] v0, input logic pt, input bit glitch,
                              input bit chain, input logic [14:0] nv, input logic npt);
      logic [13:0] a_nt, a_at, a_lo, a_hi, exp_addr;
      logic [7:0]  lo, hi;
      logic [1:0]  attr;
      int n_valid = 0;
      for (int c = 0; c <= 8 * N; c++) begin
         int  k  = c / 8;
         int  ph = c % 8;
         bit  exp_req = (c < 8 * N) && (ph % 2 == 0);
         bit  exp_vld = (c > 0) && (ph == 0);
         if (exp_req) begin
            model_tile(v0, k, pt, a_nt, a_at, a_lo, a_hi, lo, hi, attr);
            case (ph)
               0:       exp_addr = a_nt;
               2:       exp_addr = a_at;
               4:       exp_addr = a_lo;
               default: exp_addr = a_hi;
            endcase
         end
         if (exp_vld) begin
            model_tile(v0, k - 1, pt, a_nt, a_at, a_lo, a_hi, lo, hi, attr);
            exp_lo   = lo;
            exp_hi   = hi;
            exp_attr = attr;
         end
         chk_eq("mem_rd_req", 32'(mem_rd_req), 32'(exp_req));
         if (exp_req) chk_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
         chk_eq("tile_valid", 32'(tile_valid), 32'(exp_vld));
         chk_eq("tile_lo", 32'(tile_lo), 32'(exp_lo));
         chk_eq("tile_hi", 32'(tile_hi), 32'(exp_hi));
         chk_eq("tile_attr", 32'(tile_attr), 32'(exp_attr));
         chk_eq("busy", 32'(busy), 32'(c < 8 * N));
         chk_eq("line_done", 32'(line_done), 32'(c == 8 * N));
         if (tile_valid) n_valid++;
         line_start = 1'b0;
         v_addr_in  = 15'($urandom);
         if (glitch && c == 5) line_start = 1'b1;
         if (chain && c == 8 * N) begin
            line_start  = 1'b1;
            v_addr_in   = nv;
            pt_base_sel = npt;
         end
         @(negedge clk);
      end
      line_start = 1'b0;
      chk_eq("tile_count", 32'(n_valid), 32'(N));
      if (!chain) begin
         chk_eq("idle_req", 32'(mem_rd_req), 32'd0);
         chk_eq("idle_busy", 32'(busy), 32'd0);
         chk_eq("idle_valid", 32'(tile_valid), 32'd0);
         chk_eq("idle_lo_hold", 32'(tile_lo), 32'(exp_lo));
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
      chk_eq({tag, "_req"}, 32'(mem_rd_req), 32'd0);
      chk_eq({tag, "_lo"}, 32'(tile_lo), 32'd0);
      chk_eq({tag, "_hi"}, 32'(tile_hi), 32'd0);
      chk_eq({tag, "_attr"}, 32'(tile_attr), 32'd0);
      chk_eq({tag, "_valid"}, 32'(tile_valid), 32'd0);
      chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
      chk_eq({tag, "_done"}, 32'(line_done), 32'd0);
   endtask

   initial begin
      logic [14:0] cur_v, nv;
      logic        cur_pt, npt;
      bit          pending, ch;

      for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
      mem[14'h2000] = 8'h24;
      mem[14'h23C0] = 8'hE4;

      rst_n       = 1'b0;
      line_start  = 1'b0;
      v_addr_in   = '0;
      pt_base_sel = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // NT byte 0x24 at 0x2000 drives the pattern addresses of the first tile
      launch(15'h0000, 1'b0);
      check_burst(15'h0000, 1'b0, 1'b0, 1'b0, '0, 1'b0);

      // coarse X=2, coarse Y=2 selects the top quadrant of AT 0xE4; stray line_start
      // at cycle 5; back-to-back into a burst starting at coarse X=30
      nv = 15'(($urandom & 15'h7FE0) | 15'd30);
      npt = 1'($urandom);
      launch(15'h0042, 1'b1);
      check_burst(15'h0042, 1'b1, 1'b1, 1'b1, nv, npt);
      cur_v = nv;
      cur_pt = npt;
      check_burst(cur_v, cur_pt, 1'b0, 1'b0, '0, 1'b0);

      // Asynchronous reset mid-burst
      launch(15'($urandom), 1'($urandom));
      repeat (13) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      exp_lo   = '0;
      exp_hi   = '0;
      exp_attr = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_eq("post_rst_req", 32'(mem_rd_req), 32'd0);
         chk_eq("post_rst_busy", 32'(busy), 32'd0);
         @(negedge clk);
      end

      pending = 1'b0;
      cur_v   = 15'($urandom);
      cur_pt  = 1'($urandom);
      for (int i = 0; i < 7; i++) begin
         if (!pending) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch(cur_v, cur_pt);
         end
         nv  = 15'($urandom);
         npt = 1'($urandom);
         ch  = (i < 6) && ($urandom_range(0, 1) == 1);
         check_burst(cur_v, cur_pt, bit'($urandom_range(0, 1)), ch, nv, npt);
         cur_v   = nv;
         cur_pt  = npt;
         pending = ch;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
